deserializer_16bit: RTL
=======================

DESERIALIZER_16BIT -- requirements
Module: deserializer_16bit

Interface
REQ-001 Parameter: WIDTH, default 16, word length in bits; this block SHALL be built and verified at 16 only.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  begin a new word; clears partial word and bit count.
REQ-005 Port: serial_in  input  1  serial data bit, MSB first.
REQ-006 Port: bit_valid  input  1  serial_in is sampled this cycle.
REQ-007 Port: out_ready  input  1  consumer accepts data_out.
REQ-008 Port: data_out  output  16  assembled word, registered.
REQ-009 Port: out_valid  output  1  data_out holds a complete word.
REQ-010 Port: busy  output  1  high in RECV or HOLD.
REQ-011 Port: bit_count  output  5  bits received in current word, 0..16.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RECV, HOLD.
REQ-013 IDLE: busy=0, out_valid=0; bit_valid ignored; start=1 -> RECV, shift register and bit_count cleared.
REQ-014 IDLE with start=1 and bit_valid=1 in the same cycle: the bit SHALL be discarded; only start takes effect.
REQ-015 RECV, bit_valid=1: shift register SHALL load {sr[14:0], serial_in}; bit_count increments by 1.
REQ-016 RECV, bit_valid=0: shift register and bit_count SHALL hold; gaps of any length are allowed.
REQ-017 RECV, 16th valid bit (bit_count==15 and bit_valid=1): on that edge data_out SHALL load the complete word, out_valid SHALL go high, bit_count SHALL read 16, and the state SHALL become HOLD.
REQ-018 Latency: out_valid SHALL be visible in the first cycle after the edge that samples the 16th bit.
REQ-019 RECV, start=1: restart; shift register and bit_count cleared and any simultaneous bit discarded; the state SHALL remain RECV.
REQ-020 HOLD: data_out and out_valid SHALL stay stable until out_ready=1; bit_valid and start SHALL be ignored.
REQ-021 HOLD with out_ready=1: on that edge out_valid SHALL be cleared, bit_count set to 0 and the state set to IDLE; data_out SHALL retain its last value.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 A new word SHALL require a new start pulse after handshake completion; earliest start is the cycle after returning to IDLE.
REQ-024 No arithmetic overflow: bit_count SHALL never exceed 16 and SHALL never wrap.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, data_out=16'h0000, shift register=0, out_valid=0, busy=0, bit_count=0.
REQ-026 Reset mid-word or in HOLD SHALL discard all partial and pending data, with no out_valid pulse after release.
REQ-027 The first cycle after reset deassertion SHALL behave as IDLE.

Structure
REQ-028 A shared package SHALL hold the state encoding constants (IDLE, RECV, HOLD), the WIDTH default, and the bit_count width constant.
REQ-029 One sub-module SHALL be used: shift_in_register_16bit, with ports clk, rst, clear and shift_en, serial-in at the LSB and a 16-bit parallel output.
REQ-030 The FSM, bit counter and output register SHALL reside in deserializer_16bit.

Verification
REQ-031 Bench: start, then 16 back-to-back bits of 0xA5C3 MSB first -> out_valid=1 one cycle after the 16th bit, data_out=0xA5C3, bit_count=16.
REQ-032 Bench: word 0x8001 with bit_valid low for 3 cycles after bits 4 and 11 -> data_out=0x8001, out_valid only after the 16th valid bit.
REQ-033 Bench: out_ready held low for 5 cycles in HOLD while toggling bit_valid and start -> data_out stays 0xA5C3 and out_valid stays 1; out_ready=1 -> IDLE next cycle.
REQ-034 Bench: 7 bits of 1, then start, then 0x1234 -> data_out=0x1234 with no trace of the earlier 1s.
REQ-035 Bench: rst asserted after 9 bits -> all outputs 0 immediately; after release, bits without start -> no out_valid.
REQ-036 Bench: start and bit_valid together in IDLE with serial_in=1, then 0x0000 -> data_out=0x0000.

Source files
------------

// File: rtl/deserializer_16bit_pkg.sv
// ----------------------------------------------------------------------------
// deserializer_16bit_pkg
// Shared constants for the 16-bit serial-to-parallel deserializer:
//   WIDTH_DEFAULT : default word length in bits
//   COUNT_W       : width of the bit counter (must represent 0..16)
//   ST_IDLE/ST_RECV/ST_HOLD : FSM state encodings
// ----------------------------------------------------------------------------
package deserializer_16bit_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int COUNT_W       = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/deserializer_16bit_shift_in_register.sv
// ----------------------------------------------------------------------------
// shift_in_register_16bit
// Serial-in / parallel-out shift register. New bits enter at the LSB so the
// first bit received ends up in the MSB after a full word.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, clears the register
//   clear     : synchronous clear, takes priority over shift_en
//   shift_en  : shift serial_in into the LSB this cycle
//   serial_in : serial data bit
//   parallel  : current register contents
// ----------------------------------------------------------------------------
module shift_in_register_16bit
    import deserializer_16bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel
);

    // Clear wins over shift so a restart drops any bit arriving alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel <= '0;
        end else if (clear) begin
            parallel <= '0;
        end else if (shift_en) begin
            parallel <= {parallel[WIDTH-2:0], serial_in};
        end
    end

endmodule

// File: rtl/deserializer_16bit.sv
// ----------------------------------------------------------------------------
// deserializer_16bit
// Collects WIDTH serial bits (MSB first) into a word and presents it with a
// valid/ready handshake. A start pulse opens a word; the word is held until
// the consumer accepts it, after which a new start is needed.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : begin a new word (clears partial word and count)
//   serial_in : serial data bit, MSB first
//   bit_valid : serial_in is sampled this cycle
//   out_ready : consumer accepts data_out
//   data_out  : assembled word, registered
//   out_valid : data_out holds a complete word
//   busy      : high while receiving or holding a word
//   bit_count : bits received in the current word, 0..16
// ----------------------------------------------------------------------------
module deserializer_16bit
    import deserializer_16bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               serial_in,
    input  logic               bit_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               out_valid,
    output logic               busy,
    output logic [COUNT_W-1:0] bit_count
);

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_q;
    logic             in_recv;
    logic             sr_clear;
    logic             sr_shift;
    logic             last_bit;
    logic             unused_msb;

    shift_in_register_16bit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clear     (sr_clear),
        .shift_en  (sr_shift),
        .serial_in (serial_in),
        .parallel  (shift_q)
    );

    // A start in IDLE or RECV clears the partial word; any bit arriving with
    // start is dropped. Bits are only taken while receiving.
    assign in_recv  = (state == ST_RECV);
    assign sr_clear = start && ((state == ST_IDLE) || in_recv);
    assign sr_shift = in_recv && bit_valid && !start;
    assign last_bit = sr_shift && (bit_count == COUNT_W'(WIDTH - 1));
    assign busy     = (state != ST_IDLE);

    // The register MSB is shifted out by the final bit, so the completed word
    // is built from the lower bits plus the incoming bit.
    assign unused_msb = shift_q[WIDTH-1];

    // Main FSM: count bits, capture the finished word on the edge that takes
    // the last bit, then hold it until the consumer handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            data_out  <= '0;
            out_valid <= 1'b0;
            bit_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RECV;
                        bit_count <= '0;
                    end
                end
                ST_RECV: begin
                    if (start) begin
                        bit_count <= '0;
                    end else if (bit_valid) begin
                        bit_count <= bit_count + COUNT_W'(1);
                        if (last_bit) begin
                            data_out  <= {shift_q[WIDTH-2:0], serial_in};
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        bit_count <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
